// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } muldiv_state_t;

    localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    // Divide group is funct3[2]=1.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_special.sv
// Operand preparation at capture: signs, magnitudes and divide special cases.
module muldiv_special
    import muldiv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            div_by_zero,
    output logic            div_overflow,
    output logic            neg_a,
    output logic            neg_b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b
);

    logic signed_a;
    logic signed_b;

    // Signedness per opcode; 0x80000000 negates to itself, which reads
    // correctly as the unsigned magnitude 2^31.
    always_comb begin
        signed_a = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
        signed_b = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
        neg_a    = signed_a && op_a[XLEN-1];
        neg_b    = signed_b && op_b[XLEN-1];
        mag_a    = neg_a ? -op_a : op_a;
        mag_b    = neg_b ? -op_b : op_b;
        div_by_zero  = is_div_op(funct3) && (op_b == '0);
        div_overflow = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                       (op_a == INT_MIN) && (op_b == '1);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add / restoring-divide steps on
// magnitudes, then one sign-fix cycle; fixed 34-cycle latency.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t state, state_nxt;

    logic [4:0]        cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   b_mag_q;
    logic [XLEN-1:0]   a_raw_q;
    logic [2:0]        op_q;
    logic              neg_a_q, neg_b_q, dbz_q, ovf_q;

    logic              sp_dbz, sp_ovf, sp_neg_a, sp_neg_b;
    logic [XLEN-1:0]   sp_mag_a, sp_mag_b;

    logic              accept;
    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] mul_step;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_val;

    muldiv_special u_special (
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .div_by_zero  (sp_dbz),
        .div_overflow (sp_ovf),
        .neg_a        (sp_neg_a),
        .neg_b        (sp_neg_b),
        .mag_a        (sp_mag_a),
        .mag_b        (sp_mag_b)
    );

    assign accept = start && ((state == IDLE) || (state == DONE));

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // busy/done registered from the next state so both are clean flop outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == CALC) || (state_nxt == FIX);
            done <= (state_nxt == DONE);
        end
    end

    // One iteration step: acc holds {high, low} for multiply and {rem, quo}
    // for divide; the 33-bit compare covers the bit shifted out of rem.
    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b_mag_q};
        mul_step = acc[0] ? {add_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        div_ge   = acc[2*XLEN-1:XLEN-1] >= {1'b0, b_mag_q};
        div_diff = acc[2*XLEN-2:XLEN-1] - b_mag_q;
        div_step = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
    end

    // Sign correction and special-case override applied in FIX.
    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -acc : acc;
        quo  = (neg_a_q ^ neg_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_val = '0;
        case (op_q)
            F3_MUL:                      fix_val = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             fix_val = dbz_q ? DIV0_Q  : (ovf_q ? INT_MIN : quo);
            default:                     fix_val = dbz_q ? a_raw_q : (ovf_q ? '0 : rem);
        endcase
    end

    // Capture, iterate, and write result only on the FIX-to-DONE edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            b_mag_q <= '0;
            a_raw_q <= '0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            result  <= '0;
        end else if (accept) begin
            cnt     <= '0;
            acc     <= {{XLEN{1'b0}}, sp_mag_a};
            b_mag_q <= sp_mag_b;
            a_raw_q <= op_a;
            op_q    <= funct3;
            neg_a_q <= sp_neg_a;
            neg_b_q <= sp_neg_b;
            dbz_q   <= sp_dbz;
            ovf_q   <= sp_ovf;
        end else if (state == CALC) begin
            cnt <= cnt + 5'd1;
            acc <= is_div_op(op_q) ? div_step : mul_step;
        end else if (state == FIX) begin
            result <= fix_val;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Reference: RV32M semantics from full-width arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: if (b == 0) r = 32'hFFFFFFFF;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                  else r = $signed(a) / $signed(b);
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                  else r = $signed(a) % $signed(b);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
    endtask

    // Called at a negedge after issue(); returns at the negedge where done=1.
    // Inputs are scrambled while busy; poke re-asserts start mid-operation.
    task automatic wait_done(input bit poke, output int lat, output logic [31:0] res, output int busy_gaps);
        bit fin;
        lat = 0; fin = 0; busy_gaps = 0; res = 'x;
        @(posedge clk);
        while (!fin) begin
            @(negedge clk);
            lat++;
            if (done) begin
                res = result;
                if (busy) busy_gaps++;
                fin = 1;
            end else begin
                if (!busy) busy_gaps++;
                if (lat >= 100) fin = 1;
            end
            start  = poke && (lat == 5);
            funct3 = 3'($urandom);
            op_a   = $urandom;
            op_b   = $urandom;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat, gaps;
        logic [31:0] res;
        issue(f, a, b);
        wait_done(1'b0, lat, res, gaps);
        check({tag, "_res"}, res, exp);
        check({tag, "_lat"}, 32'(lat), 32'd34);
        check({tag, "_busy"}, 32'(gaps), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  dir_f [20] = '{3'd1, 3'd2, 3'd3, 3'd0,
                                3'd4, 3'd6, 3'd5, 3'd7,
                                3'd4, 3'd5, 3'd6, 3'd7,
                                3'd4, 3'd6,
                                3'd1, 3'd3, 3'd2, 3'd4, 3'd4, 3'd6};
    logic [31:0] dir_a [20] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678,
                                32'h80000000, 32'h80000000,
                                32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                                32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] dir_b [20] = '{32'h2, 32'h2, 32'h2, 32'h2,
                                32'h2, 32'h2, 32'h2, 32'h2,
                                32'h0, 32'h0, 32'h0, 32'h0,
                                32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h2,
                                32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] dir_e [20] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE,
                                32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h12345678,
                                32'h80000000, 32'h00000000,
                                32'h40000000, 32'h40000000, 32'h80000000, 32'hC0000000,
                                32'h00000003, 32'hFFFFFFFF};

    initial begin
        int lat, gaps, dones;
        logic [31:0] res, a, b;
        logic [2:0]  f;

        rst_n = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   32'(busy),  32'd0);
        check("rst_done",   32'(done),  32'd0);
        check("rst_result", result,     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul3x4", F3_MUL, 32'd3, 32'd4, 32'd12);

        // Reset at edge E+10 of an in-flight multiply.
        issue(F3_MUL, 32'd5, 32'd6);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy",   32'(busy), 32'd0);
        check("midrst_done",   32'(done), 32'd0);
        check("midrst_result", result,    32'd0);
        rst_n = 1'b1;
        dones = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        run_op("mul3x4_again", F3_MUL, 32'd3, 32'd4, 32'd12);

        for (int i = 0; i < 20; i++)
            run_op($sformatf("dir%0d_f%0d", i, dir_f[i]), dir_f[i], dir_a[i], dir_b[i], dir_e[i]);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op($sformatf("rnd%0d_f%0d_%08h_%08h", i, f, a, b), f, a, b, model(f, a, b));
        end

        // start during CALC is ignored.
        a = $urandom; b = 32'($urandom_range(1, 1000));
        issue(F3_DIVU, a, b);
        wait_done(1'b1, lat, res, gaps);
        check("poke_res", res, model(F3_DIVU, a, b));
        check("poke_lat", 32'(lat), 32'd34);
        dones = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("poke_single_done", 32'(dones), 32'd0);

        // Back-to-back: start in the DONE cycle.
        a = $urandom; b = $urandom;
        issue(F3_MULHU, a, b);
        wait_done(1'b0, lat, res, gaps);
        check("b2b_first_res", res, model(F3_MULHU, a, b));
        a = $urandom; b = 32'($urandom_range(1, 99));
        issue(F3_REM, a, b);
        wait_done(1'b0, lat, res, gaps);
        check("b2b_second_res", res, model(F3_REM, a, b));
        check("b2b_spacing", 32'(lat), 32'd34);
        @(negedge clk);
        check("b2b_done_width", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
